// File: rtl/mem_arb_pkg.sv
//------------------------------------------------------------------------------
// mem_arb_pkg: shared widths and enums for the memory port arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [0:0] {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/arb_streak_ctr.sv
//------------------------------------------------------------------------------
// arb_streak_ctr: saturating count of consecutive D grants made while IF waits.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module arb_streak_ctr #(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CW = $clog2(MAX_STREAK + 1);
  localparam logic [CW-1:0] C_MAX = CW'(MAX_STREAK);

  logic [CW-1:0] r_cnt;

  // Clear wins over increment; the two are never asserted together by the top.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != C_MAX)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign at_max = (r_cnt == C_MAX);

endmodule : arb_streak_ctr

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// mem_port_arbiter: shares one memory port between instruction fetch and
// load/store, D-priority with an anti-starvation streak limit. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MAX_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,

  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic                d_req_we,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wstrb,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_data,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_we,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,

  output logic                busy,
  output logic                stray_rsp
);

  state_t r_state;
  state_t w_state_nxt;
  owner_t r_owner;
  owner_t w_owner_nxt;
  logic   r_stray;

  logic   w_at_max;
  logic   w_sel_d;
  logic   w_sel_if;
  logic   w_hs;
  logic   w_streak_inc;
  logic   w_streak_clr;

  // Selection is recomputed every IDLE cycle, so a dropped request simply
  // stops being selected.
  assign w_sel_d  = d_req_valid && !(if_req_valid && w_at_max);
  assign w_sel_if = !w_sel_d && if_req_valid;

  assign w_hs = rst && (r_state == ST_IDLE) && (w_sel_d || w_sel_if) && mem_req_ready;

  assign w_streak_inc = w_hs && w_sel_d && if_req_valid;
  assign w_streak_clr = w_hs && (w_sel_if || (w_sel_d && !if_req_valid));

  arb_streak_ctr #(
    .MAX_STREAK (MAX_STREAK)
  ) u_streak (
    .clk    (clk),
    .rst    (rst),
    .inc    (w_streak_inc),
    .clr    (w_streak_clr),
    .at_max (w_at_max)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWNER_IF;
      r_stray <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      if ((r_state == ST_IDLE) && mem_rsp_valid) begin
        r_stray <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    mem_req_valid = 1'b0;
    mem_req_addr  = if_req_addr;
    mem_req_we    = 1'b0;
    mem_req_wdata = '0;
    mem_req_wstrb = '0;
    if_req_ready  = 1'b0;
    d_req_ready   = 1'b0;
    if_rsp_valid  = 1'b0;
    d_rsp_valid   = 1'b0;
    busy          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_sel_d) begin
          mem_req_valid = 1'b1;
          mem_req_addr  = d_req_addr;
          mem_req_we    = d_req_we;
          mem_req_wdata = d_req_wdata;
          mem_req_wstrb = d_req_wstrb;
          d_req_ready   = mem_req_ready;
        end else if (w_sel_if) begin
          mem_req_valid = 1'b1;
          mem_req_addr  = if_req_addr;
          if_req_ready  = mem_req_ready;
        end
        if (w_hs) begin
          w_state_nxt = ST_WAIT;
          w_owner_nxt = w_sel_d ? OWNER_D : OWNER_IF;
        end
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (mem_rsp_valid) begin
          if (r_owner == OWNER_D) begin
            d_rsp_valid = 1'b1;
          end else begin
            if_rsp_valid = 1'b1;
          end
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Handshake outputs are held low for the whole time reset is asserted.
    if (!rst) begin
      mem_req_valid = 1'b0;
      if_req_ready  = 1'b0;
      d_req_ready   = 1'b0;
      if_rsp_valid  = 1'b0;
      d_rsp_valid   = 1'b0;
      busy          = 1'b0;
    end
  end

  assign if_rsp_data = mem_rsp_data;
  assign d_rsp_data  = mem_rsp_data;
  assign stray_rsp   = r_stray;

endmodule : mem_port_arbiter

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;
  logic              d_req_valid;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_req_addr;
  logic              d_req_we;
  logic [DATA_W-1:0] d_req_wdata;
  logic [3:0]        d_req_wstrb;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rsp_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_we;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [3:0]        mem_req_wstrb;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              busy;
  logic              stray_rsp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MAX_STREAK (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_req_addr   (if_req_addr),
    .if_rsp_valid  (if_rsp_valid),
    .if_rsp_data   (if_rsp_data),
    .d_req_valid   (d_req_valid),
    .d_req_ready   (d_req_ready),
    .d_req_addr    (d_req_addr),
    .d_req_we      (d_req_we),
    .d_req_wdata   (d_req_wdata),
    .d_req_wstrb   (d_req_wstrb),
    .d_rsp_valid   (d_rsp_valid),
    .d_rsp_data    (d_rsp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_we    (mem_req_we),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .busy          (busy),
    .stray_rsp     (stray_rsp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle mid-cycle before sampling.
  task automatic settle();
    #2;
  endtask

  int  n_grant;
  bit  grant_d [10];
  bit  exp_d   [10];

  initial begin
    rst           = 1'b0;
    if_req_valid  = 1'b0;
    if_req_addr   = '0;
    d_req_valid   = 1'b0;
    d_req_addr    = '0;
    d_req_we      = 1'b0;
    d_req_wdata   = '0;
    d_req_wstrb   = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;

    // Reset: outputs forced low even with requests pending.
    step();
    if_req_valid  = 1'b1;
    mem_req_ready = 1'b1;
    settle();
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_if_req_ready",  64'(if_req_ready),  64'd0);
    chk("rst_busy",          64'(busy),          64'd0);
    chk("rst_stray",         64'(stray_rsp),     64'd0);
    if_req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();

    // Test 1: IF read, response after 3 cycles.
    if_req_valid  = 1'b1;
    if_req_addr   = 32'h0000_0010;
    mem_req_ready = 1'b1;
    settle();
    chk("t1_if_req_ready", 64'(if_req_ready), 64'd1);
    chk("t1_mem_addr",     64'(mem_req_addr), 64'h10);
    chk("t1_mem_we",       64'(mem_req_we),   64'd0);
    chk("t1_busy_idle",    64'(busy),         64'd0);
    step();
    if_req_valid = 1'b0;
    settle();
    chk("t1_busy_w1", 64'(busy), 64'd1);
    chk("t1_no_rsp",  64'(if_rsp_valid), 64'd0);
    step();
    settle();
    chk("t1_busy_w2", 64'(busy), 64'd1);
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEAD_BEEF;
    settle();
    chk("t1_busy_w3",      64'(busy),         64'd1);
    chk("t1_if_rsp_valid", 64'(if_rsp_valid), 64'd1);
    chk("t1_if_rsp_data",  64'(if_rsp_data),  64'hDEAD_BEEF);
    chk("t1_d_rsp_valid",  64'(d_rsp_valid),  64'd0);
    step();
    mem_rsp_valid = 1'b0;
    settle();
    chk("t1_busy_after",   64'(busy),         64'd0);
    chk("t1_rsp_pulse",    64'(if_rsp_valid), 64'd0);

    // Test 2: simultaneous IF and D; D write wins, IF follows.
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0000_0200;
    d_req_valid  = 1'b1;
    d_req_addr   = 32'h0000_0100;
    d_req_we     = 1'b1;
    d_req_wdata  = 32'h1234_5678;
    d_req_wstrb  = 4'b1111;
    settle();
    chk("t2_d_ready",   64'(d_req_ready),   64'd1);
    chk("t2_if_ready",  64'(if_req_ready),  64'd0);
    chk("t2_mem_addr",  64'(mem_req_addr),  64'h100);
    chk("t2_mem_we",    64'(mem_req_we),    64'd1);
    chk("t2_mem_wdata", 64'(mem_req_wdata), 64'h1234_5678);
    chk("t2_mem_wstrb", 64'(mem_req_wstrb), 64'hF);
    step();
    d_req_valid   = 1'b0;
    d_req_we      = 1'b0;
    mem_rsp_valid = 1'b1;
    settle();
    chk("t2_d_rsp_valid",  64'(d_rsp_valid),   64'd1);
    chk("t2_if_rsp_valid", 64'(if_rsp_valid),  64'd0);
    chk("t2_if_ready_w",   64'(if_req_ready),  64'd0);
    chk("t2_mem_valid_w",  64'(mem_req_valid), 64'd0);
    step();
    mem_rsp_valid = 1'b0;
    settle();
    chk("t2_if_ready",   64'(if_req_ready),  64'd1);
    chk("t2_if_addr",    64'(mem_req_addr),  64'h200);
    chk("t2_if_we",      64'(mem_req_we),    64'd0);
    chk("t2_if_wdata",   64'(mem_req_wdata), 64'd0);
    chk("t2_if_wstrb",   64'(mem_req_wstrb), 64'd0);
    step();
    if_req_valid  = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hCAFE_0001;
    settle();
    chk("t2_if_rsp", 64'(if_rsp_valid), 64'd1);
    chk("t2_d_quiet", 64'(d_rsp_valid), 64'd0);
    step();
    mem_rsp_valid = 1'b0;

    // Test 3: continuous contention, streak limit 4.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    exp_d = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0000_1000;
    d_req_valid  = 1'b1;
    d_req_addr   = 32'h0000_2000;
    n_grant      = 0;
    for (int cyc = 0; cyc < 40 && n_grant < 10; cyc++) begin
      mem_rsp_valid = busy;
      settle();
      if (d_req_ready) begin
        grant_d[n_grant] = 1'b1;
        n_grant++;
      end else if (if_req_ready) begin
        grant_d[n_grant] = 1'b0;
        n_grant++;
      end
      step();
    end
    chk("t3_grant_count", 64'(n_grant), 64'd10);
    for (int g = 0; g < n_grant; g++) begin
      chk($sformatf("t3_grant%0d_is_d", g), 64'(grant_d[g]), 64'(exp_d[g]));
    end
    if_req_valid  = 1'b0;
    d_req_valid   = 1'b0;
    mem_rsp_valid = busy;
    step();
    mem_rsp_valid = 1'b0;
    settle();
    chk("t3_idle", 64'(busy), 64'd0);
    chk("t3_stray_clear", 64'(stray_rsp), 64'd0);
    step();

    // Test 4: memory back-pressure.
    mem_req_ready = 1'b0;
    d_req_valid   = 1'b1;
    d_req_addr    = 32'h0000_0300;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk($sformatf("t4_stall%0d_ready", k), 64'(d_req_ready), 64'd0);
      chk($sformatf("t4_stall%0d_busy", k),  64'(busy),        64'd0);
      step();
    end
    mem_req_ready = 1'b1;
    settle();
    chk("t4_grant_ready", 64'(d_req_ready),  64'd1);
    chk("t4_grant_addr",  64'(mem_req_addr), 64'h300);
    step();
    d_req_valid   = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0000_A5A5;
    settle();
    chk("t4_busy",       64'(busy),        64'd1);
    chk("t4_d_rsp",      64'(d_rsp_valid), 64'd1);
    chk("t4_d_rsp_data", 64'(d_rsp_data),  64'hA5A5);
    step();
    mem_rsp_valid = 1'b0;

    // Test 5: reset during WAIT, then a late response.
    d_req_valid = 1'b1;
    d_req_addr  = 32'h0000_0500;
    settle();
    chk("t5_grant", 64'(d_req_ready), 64'd1);
    step();
    d_req_valid = 1'b0;
    settle();
    chk("t5_busy_wait", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("t5_busy_in_rst", 64'(busy), 64'd0);
    step();
    rst = 1'b1;
    settle();
    chk("t5_busy_after_rst", 64'(busy),      64'd0);
    chk("t5_stray_pre",      64'(stray_rsp), 64'd0);
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0BAD_0BAD;
    settle();
    chk("t5_no_if_rsp", 64'(if_rsp_valid), 64'd0);
    chk("t5_no_d_rsp",  64'(d_rsp_valid),  64'd0);
    step();
    mem_rsp_valid = 1'b0;
    settle();
    chk("t5_stray_set", 64'(stray_rsp), 64'd1);
    step();
    step();
    settle();
    chk("t5_stray_sticky", 64'(stray_rsp), 64'd1);
    step();

    // Test 6: back-to-back IF reads, response right after handshake.
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0000_0400;
    settle();
    chk("t6_first_ready", 64'(if_req_ready), 64'd1);
    step();
    if_req_addr   = 32'h0000_0404;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h1111_2222;
    settle();
    chk("t6_rsp1",        64'(if_rsp_valid), 64'd1);
    chk("t6_rsp1_data",   64'(if_rsp_data),  64'h1111_2222);
    chk("t6_no_early",    64'(if_req_ready), 64'd0);
    step();
    mem_rsp_valid = 1'b0;
    settle();
    chk("t6_second_ready", 64'(if_req_ready), 64'd1);
    chk("t6_second_addr",  64'(mem_req_addr), 64'h404);
    step();
    if_req_valid  = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h3333_4444;
    settle();
    chk("t6_rsp2",      64'(if_rsp_valid), 64'd1);
    chk("t6_rsp2_data", 64'(if_rsp_data),  64'h3333_4444);
    step();
    mem_rsp_valid = 1'b0;
    settle();
    chk("t6_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mem_port_arbiter

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port of cpu_top between two requesters: the instruction-fetch unit (port IF) and the load/store unit (port D).
- Arbitrates requests and holds exactly one outstanding transaction at a time.
- Routes each memory response back to the requester that issued it.
- Data-side requests have priority, with a streak limit so instruction fetch cannot starve.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MAX_STREAK, 4, maximum consecutive D grants while IF is waiting; must be >= 1

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
if_req_valid  input  1  IF read request valid
if_req_ready  output  1  IF request accepted this cycle
if_req_addr  input  ADDR_W  IF read address
if_rsp_valid  output  1  IF response valid, 1-cycle pulse
if_rsp_data  output  DATA_W  IF read data
d_req_valid  input  1  D request valid
d_req_ready  output  1  D request accepted this cycle
d_req_addr  input  ADDR_W  D address
d_req_we  input  1  D write enable
d_req_wdata  input  DATA_W  D write data
d_req_wstrb  input  DATA_W/8  D byte strobes
d_rsp_valid  output  1  D response valid (read data or write ack), 1-cycle pulse
d_rsp_data  output  DATA_W  D read data; undefined for writes
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  ADDR_W  muxed address
mem_req_we  output  1  muxed write enable; 0 for IF
mem_req_wdata  output  DATA_W  muxed write data; 0 for IF
mem_req_wstrb  output  DATA_W/8  muxed strobes; 0 for IF
mem_rsp_valid  input  1  memory response valid
mem_rsp_data  input  DATA_W  memory read data
busy  output  1  transaction outstanding (state WAIT)
stray_rsp  output  1  sticky flag: mem_rsp_valid seen in IDLE

Behaviour:
- States: IDLE, WAIT. Registers: state, owner (IF/D), streak counter, stray_rsp.
- Reset (rst=0, async):
  - state=IDLE, owner=IF, streak=0, stray_rsp=0.
  - All valid/ready outputs, and busy, are forced to 0 for as long as rst=0.
- IDLE, selection:
  - Select D if d_req_valid and not (if_req_valid and streak==MAX_STREAK).
  - Otherwise select IF if if_req_valid.
  - Otherwise select nothing.
- IDLE, request path:
  - mem_req_valid = selected requester's valid, and mem_req_* come from the selected requester (all combinational).
  - The selected requester's ready = mem_req_ready. The other requester's ready = 0.
  - Requesters must hold their req fields stable until ready.
- Handshake (mem_req_valid & mem_req_ready):
  - On the next edge: owner <= selected requester, state <= WAIT.
  - Streak update:
    - D granted while if_req_valid=1: streak increments, saturating at MAX_STREAK.
    - IF granted: streak <= 0.
    - D granted with if_req_valid=0: streak <= 0.
- WAIT:
  - mem_req_valid=0, both ready=0, busy=1.
  - On mem_rsp_valid: the owner's rsp_valid=1 (combinational pass-through) and rsp_data=mem_rsp_data; state <= IDLE.
  - The non-owner's rsp_valid stays 0.
- Response data outputs carry mem_rsp_data continuously; only the rsp_valid signals gate them.
- Latency:
  - Request is accepted in the same cycle as mem_req_ready.
  - Response returns to the requester in the same cycle as mem_rsp_valid.
  - A new request can be accepted no earlier than the cycle after the response, so minimum spacing is 2 cycles per transaction.
- Memory latency is unbounded. There is no timeout; busy stays 1 until a response arrives.
- Boundaries:
  - mem_rsp_valid in IDLE (including in the same cycle as a handshake) is dropped and sets stray_rsp; it clears only on reset.
  - mem_req_ready without mem_req_valid has no effect.
  - A requester dropping valid before ready is a protocol error; the arbiter re-evaluates selection every IDLE cycle and does not check for it.
  - Reset while in WAIT abandons the transaction. A late response then sets stray_rsp.

Decomposition:
- Package mem_arb_pkg: ADDR_W/DATA_W defaults; owner_t enum {OWNER_IF=0, OWNER_D=1}; state_t enum {ST_IDLE, ST_WAIT}.
- Sub-module arb_streak_ctr: saturating counter of width $clog2(MAX_STREAK+1), with inputs inc, clr, and output at_max.

Test Plan:
1. Reset, then IF read 0x0000_0010, mem_req_ready=1, response 0xDEAD_BEEF after 3 cycles -> if_req_ready same cycle; busy=1 for 3 cycles; if_rsp_valid 1-cycle pulse with 0xDEAD_BEEF; d_rsp_valid=0.
2. IF and D both valid in the same cycle, D write 0x100 data 0x1234_5678 wstrb 4'b1111 -> D granted first; mem_req_we=1; d_rsp_valid on ack; IF granted on the next IDLE cycle.
3. MAX_STREAK=4, D valid continuously, IF valid continuously -> grant order D,D,D,D,IF,D,D,D,D,IF.
4. mem_req_ready held 0 for 5 cycles with D valid -> d_req_ready=0 and state stays IDLE; grant occurs in the cycle mem_req_ready=1.
5. rst asserted while in WAIT, deasserted, then mem_rsp_valid=1 -> no rsp_valid to either port; stray_rsp=1 and stays 1.
6. IF read with mem_rsp_valid arriving the cycle after the handshake, then an immediate second IF request -> second handshake no earlier than the cycle after the first response; no request is lost.
